// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the decode-stage branch comparator.
// Holds the datapath width and the cmp_op condition encodings. The decode
// controller drives cmp_op from these same constants.
package cpu_pkg;

   // Datapath operand width
   localparam int unsigned WIDTH = 32;

   // Width of the condition-select field
   localparam int unsigned CMP_OP_W = 3;

   // Number of distinct branch conditions (every cmp_op value is defined)
   localparam int unsigned CMP_N_OPS = 8;

   // Branch condition encodings
   localparam logic [CMP_OP_W-1:0] CMP_EQ  = 3'd0;  // rs == rt
   localparam logic [CMP_OP_W-1:0] CMP_NE  = 3'd1;  // rs != rt
   localparam logic [CMP_OP_W-1:0] CMP_LEZ = 3'd2;  // rs <= 0 (signed)
   localparam logic [CMP_OP_W-1:0] CMP_GTZ = 3'd3;  // rs >  0 (signed)
   localparam logic [CMP_OP_W-1:0] CMP_LTZ = 3'd4;  // rs <  0 (signed)
   localparam logic [CMP_OP_W-1:0] CMP_GEZ = 3'd5;  // rs >= 0 (signed)
   localparam logic [CMP_OP_W-1:0] CMP_LT  = 3'd6;  // rs <  rt (signed)
   localparam logic [CMP_OP_W-1:0] CMP_LTU = 3'd7;  // rs <  rt (unsigned)

endpackage : cpu_pkg

// File: rtl/cmp_core.sv
// Combinational branch comparator core.
// Derives the raw relation flags of two operands and selects the branch
// decision for the requested condition. No state.
// Ports:
//   a        operand A (rs, forwarded)
//   b        operand B (rt, forwarded)
//   op       condition select (cpu_pkg CMP_* encodings)
//   out_c    selected branch decision
//   eq_c     a == b
//   lt_s_c   signed(a) < signed(b)
//   lt_u_c   unsigned a < b
module cmp_core #(
   parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic [cpu_pkg::CMP_OP_W-1:0] op,
   output logic                         out_c,
   output logic                         eq_c,
   output logic                         lt_s_c,
   output logic                         lt_u_c
);

   import cpu_pkg::CMP_N_OPS;
   import cpu_pkg::CMP_EQ;
   import cpu_pkg::CMP_NE;
   import cpu_pkg::CMP_LEZ;
   import cpu_pkg::CMP_GTZ;
   import cpu_pkg::CMP_LTZ;
   import cpu_pkg::CMP_GEZ;
   import cpu_pkg::CMP_LT;
   import cpu_pkg::CMP_LTU;

   logic                 a_neg;
   logic                 a_zero;
   logic [CMP_N_OPS-1:0] cond;

   // Two-operand relations
   always_comb begin
      eq_c   = (a == b);
      lt_s_c = ($signed(a) < $signed(b));
      lt_u_c = (a < b);
   end

   // Zero-compare terms look at operand A only
   always_comb begin
      a_neg  = a[WIDTH-1];
      a_zero = (a == '0);
   end

   // One decision per condition, indexed by its encoding
   always_comb begin
      cond          = '0;
      cond[CMP_EQ]  = eq_c;
      cond[CMP_NE]  = ~eq_c;
      cond[CMP_LEZ] = a_neg | a_zero;
      cond[CMP_GTZ] = ~a_neg & ~a_zero;
      cond[CMP_LTZ] = a_neg;
      cond[CMP_GEZ] = ~a_neg;
      cond[CMP_LT]  = lt_s_c;
      cond[CMP_LTU] = lt_u_c;
   end

   // Indexed select rather than a case so an unknown op shows up as X
   always_comb begin
      out_c = cond[op];
   end

endmodule : cmp_core

// File: rtl/cmp.sv
// Decode-stage branch comparator.
// Produces the same-cycle branch decision for next-PC selection, the raw
// relation flags, and a registered copy of the decision for later stages.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   CMP1        operand A (rs, forwarded)
//   CMP2        operand B (rt, forwarded)
//   cmp_op      condition select (cpu_pkg CMP_* encodings)
//   en          register update enable, low while the pipeline stalls
//   CMP_Output  combinational branch decision
//   cmp_q       registered branch decision
//   eq          combinational CMP1 == CMP2
//   lt_s        combinational signed CMP1 < CMP2
//   lt_u        combinational unsigned CMP1 < CMP2
module cmp #(
   parameter int unsigned WIDTH = cpu_pkg::WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH-1:0]             CMP1,
   input  logic [WIDTH-1:0]             CMP2,
   input  logic [cpu_pkg::CMP_OP_W-1:0] cmp_op,
   input  logic                         en,
   output logic                         CMP_Output,
   output logic                         cmp_q,
   output logic                         eq,
   output logic                         lt_s,
   output logic                         lt_u
);

   logic cmp_d;

   cmp_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (CMP1),
      .b      (CMP2),
      .op     (cmp_op),
      .out_c  (CMP_Output),
      .eq_c   (eq),
      .lt_s_c (lt_s),
      .lt_u_c (lt_u)
   );

   // Hold the captured decision while the pipeline is stalled
   always_comb begin
      cmp_d = cmp_q;
      if (en) begin
         cmp_d = CMP_Output;
      end
   end

   // Decision register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_q <= 1'b0;
      end else begin
         cmp_q <= cmp_d;
      end
   end

endmodule : cmp

// File: tb/tb_cmp.sv
// Self-checking bench for the branch comparator: directed cases plus
// randomized operand/op triples against an arithmetic reference model.
module tb_cmp;

   import cpu_pkg::CMP_EQ;
   import cpu_pkg::CMP_NE;
   import cpu_pkg::CMP_LEZ;
   import cpu_pkg::CMP_GTZ;
   import cpu_pkg::CMP_LTZ;
   import cpu_pkg::CMP_GEZ;
   import cpu_pkg::CMP_LT;
   import cpu_pkg::CMP_LTU;

   logic        clk;
   logic        rst_n;
   logic [31:0] CMP1;
   logic [31:0] CMP2;
   logic [2:0]  cmp_op;
   logic        en;
   logic        CMP_Output;
   logic        cmp_q;
   logic        eq;
   logic        lt_s;
   logic        lt_u;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string name;
      logic  e_out;
      logic  e_eq;
      logic  e_lts;
      logic  e_ltu;
      logic  e_q;
   } exp_t;

   exp_t sb[$];

   cmp #(
      .WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .CMP1       (CMP1),
      .CMP2       (CMP2),
      .cmp_op     (cmp_op),
      .en         (en),
      .CMP_Output (CMP_Output),
      .cmp_q      (cmp_q),
      .eq         (eq),
      .lt_s       (lt_s),
      .lt_u       (lt_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference relations computed as integer arithmetic on 64-bit values
   function automatic logic m_lts(input logic [31:0] a, input logic [31:0] b);
      return longint'(int'(a)) < longint'(int'(b));
   endfunction

   function automatic logic m_ltu(input logic [31:0] a, input logic [31:0] b);
      return longint'(a) < longint'(b);
   endfunction

   function automatic logic model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      longint sa;
      sa = longint'(int'(a));
      case (op)
         CMP_EQ:  return a == b;
         CMP_NE:  return a != b;
         CMP_LEZ: return sa <= 0;
         CMP_GTZ: return sa > 0;
         CMP_LTZ: return sa < 0;
         CMP_GEZ: return sa >= 0;
         CMP_LT:  return m_lts(a, b);
         default: return m_ltu(a, b);
      endcase
   endfunction

   // Reference for the decision register
   logic mq = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  mq <= 1'b0;
      else if (en) mq <= model(cmp_op, CMP1, CMP2);
   end

   task automatic chk(input string name, input string field, input logic act,
                      input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %b expected %b (op=%0d a=%h b=%h)",
                  name, field, act, exp, cmp_op, CMP1, CMP2);
      end
   endtask

   // Monitor: compares every pending expectation once per cycle, mid-period
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "out",   CMP_Output, e.e_out);
            chk(e.name, "eq",    eq,         e.e_eq);
            chk(e.name, "lt_s",  lt_s,       e.e_lts);
            chk(e.name, "lt_u",  lt_u,       e.e_ltu);
            chk(e.name, "cmp_q", cmp_q,      e.e_q);
         end
      end
   end

   // Drive one input set just after a clock edge and queue its expectation
   task automatic apply(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic e, input logic r);
      exp_t x;
      @(posedge clk);
      #1;
      cmp_op = op;
      CMP1   = a;
      CMP2   = b;
      en     = e;
      rst_n  = r;
      #1;
      x.name  = name;
      x.e_out = model(op, a, b);
      x.e_eq  = (a == b);
      x.e_lts = m_lts(a, b);
      x.e_ltu = m_ltu(a, b);
      x.e_q   = mq;
      sb.push_back(x);
   endtask

   initial begin
      logic [31:0] zv [3];
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      zv[0] = 32'h0000_0000;
      zv[1] = 32'hFFFF_FFFF;
      zv[2] = 32'h0000_0001;

      rst_n  = 1'b0;
      en     = 1'b0;
      cmp_op = CMP_EQ;
      CMP1   = '0;
      CMP2   = '0;

      // Combinational path alive during reset
      apply("rst_eq", CMP_EQ, 32'h0, 32'h0, 1'b1, 1'b0);
      apply("rst_eq2", CMP_EQ, 32'h0, 32'h0, 1'b1, 1'b0);

      // Capture a 1, then assert reset between edges
      apply("pre_rst", CMP_NE, 32'h1, 32'h2, 1'b1, 1'b1);
      apply("pre_rst2", CMP_NE, 32'h1, 32'h2, 1'b1, 1'b1);
      apply("mid_rst", CMP_NE, 32'h1, 32'h2, 1'b1, 1'b0);
      apply("rel_rst", CMP_NE, 32'h1, 32'h2, 1'b1, 1'b1);

      // EQ / NE
      apply("eq_same", CMP_EQ, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
      apply("ne_same", CMP_NE, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
      apply("eq_diff", CMP_EQ, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1);
      apply("ne_diff", CMP_NE, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1);

      // Zero compares with arbitrary CMP2
      for (int v = 0; v < 3; v++) begin
         for (int op = 2; op <= 5; op++) begin
            apply("zero_op", 3'(op), zv[v], $urandom(), 1'b1, 1'b1);
         end
      end

      // Signed vs unsigned extremes
      apply("lt_min_max",  CMP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
      apply("ltu_min_max", CMP_LTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
      apply("lt_max_min",  CMP_LT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
      apply("ltu_max_min", CMP_LTU, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);

      // Enable: capture 1, stall with equal operands, then release
      apply("en_set",   CMP_NE, 32'hA, 32'hB, 1'b1, 1'b1);
      apply("en_cap",   CMP_NE, 32'hA, 32'hB, 1'b1, 1'b1);
      apply("en_stall", CMP_NE, 32'hC, 32'hC, 1'b0, 1'b1);
      apply("en_hold",  CMP_NE, 32'hC, 32'hC, 1'b0, 1'b1);
      apply("en_rel",   CMP_NE, 32'hC, 32'hC, 1'b1, 1'b1);
      apply("en_upd",   CMP_NE, 32'hC, 32'hC, 1'b1, 1'b1);

      // Random triples, biased toward equal and boundary operands
      for (int i = 0; i < 10000; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'h7FFF_FFFF;
            2:       ra = 32'($urandom_range(0, 2)) - 32'd1;
            default: ra = $urandom();
         endcase
         case ($urandom_range(0, 5))
            0:       rb = ra;
            1:       rb = ra + 32'd1;
            2:       rb = 32'h8000_0000;
            default: rb = $urandom();
         endcase
         apply("rand", rop, ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_cmp

// File: doc/cmp.md
Name: cmp

Overview:
- Branch comparator in the decode (D) stage of the team's 5-stage pipelined MIPS CPU.
- Compares two 32-bit forwarded register operands, CMP1 (rs) and CMP2 (rt).
- Produces the combinational branch-taken decision CMP_Output for the selected branch condition, used for next-PC selection in the same cycle.
- Also provides a registered copy of the decision and raw relation flags for downstream stages and the debug path.

Parameters:
- WIDTH, 32, operand width in bits.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- CMP1  input  WIDTH  operand A (rs value, after forwarding).
- CMP2  input  WIDTH  operand B (rt value, after forwarding).
- cmp_op  input  3  condition select: 0 EQ, 1 NE, 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ, 6 LT signed, 7 LTU unsigned.
- en  input  1  register update enable; low during a pipeline stall.
- CMP_Output  output  1  combinational condition result.
- cmp_q  output  1  registered CMP_Output.
- eq  output  1  combinational flag, CMP1 == CMP2.
- lt_s  output  1  combinational flag, signed(CMP1) < signed(CMP2).
- lt_u  output  1  combinational flag, unsigned CMP1 < CMP2.

Behaviour:
- CMP_Output, eq, lt_s and lt_u are purely combinational, with zero-cycle latency.
- They do not depend on clk or rst_n.
- Condition definitions:
  - EQ: CMP1 == CMP2.
  - NE: CMP1 != CMP2.
  - LEZ: CMP1[31] set, or CMP1 == 0.
  - GTZ: CMP1[31] clear and CMP1 != 0.
  - LTZ: CMP1[31] set.
  - GEZ: CMP1[31] clear.
  - LT: the lt_s flag.
  - LTU: the lt_u flag.
- Zero-compare ops (LEZ, GTZ, LTZ, GEZ) ignore CMP2 entirely.
- Signed compare is two's complement: 32'h80000000 is the minimum value, 32'h7FFFFFFF the maximum.
- Unsigned compare treats all operands as 0 to 2^32-1.
- All opcode values 0-7 are defined; there is no illegal opcode.
- X on an input propagates to the output; no masking.
- cmp_q register:
  - rst_n low → cmp_q = 0 immediately, asynchronously, and held while rst_n is low.
  - On a rising clk edge with rst_n high and en = 1 → cmp_q takes CMP_Output.
  - With en = 0 → cmp_q holds its value.
- Reset deassertion takes effect at the next clk edge; the first capture occurs at the first rising edge with rst_n high and en = 1.
- Reset asserted in mid-operation overrides en in the same cycle.
- No handshake and no state machine.

Decomposition:
- Shared package cpu_pkg holds:
  - the cmp_op encodings as named constants (CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ, CMP_LT, CMP_LTU);
  - WIDTH.
- The decode controller produces cmp_op from the same constants.
- Sub-module cmp_core: purely combinational flags plus the op mux.
- The top level adds only the cmp_q register.

Test Plan:
- Reset: rst_n = 0 between clock edges → cmp_q = 0 immediately. With CMP1 = CMP2 = 0 and cmp_op = EQ → CMP_Output = 1 and eq = 1, even during reset.
- EQ/NE: CMP1 = 32'h12345678, CMP2 = 32'h12345678 → EQ = 1, NE = 0. Change CMP2 to 32'h12345679 → EQ = 0, NE = 1, in the same delta cycle.
- Zero ops:
  - CMP1 = 0 → LEZ 1, GTZ 0, LTZ 0, GEZ 1.
  - CMP1 = 32'hFFFFFFFF → LEZ 1, GTZ 0, LTZ 1, GEZ 0.
  - CMP1 = 1 → LEZ 0, GTZ 1, LTZ 0, GEZ 1.
  - CMP2 = random throughout, with no effect on any of these results.
- Signed vs unsigned: CMP1 = 32'h80000000, CMP2 = 32'h7FFFFFFF → lt_s = 1, lt_u = 0. Swap the operands → lt_s = 0, lt_u = 1.
- Register enable: cmp_op = NE with unequal operands and en = 1, clock edge → cmp_q = 1. Set en = 0 and make the operands equal, clock edge → cmp_q stays 1. Set en = 1, clock edge → cmp_q = 0.
- Random: 10k random operand/op triples checked against a behavioural model on all four combinational outputs.
